mult_reservation_station: RTL and testbench
===========================================

MULT_RESERVATION_STATION -- requirements
Module: mult_reservation_station

Interface
REQ-001 SHALL have parameters: DEPTH, 4, number of entries (2..8).
REQ-002 SHALL have parameters: DATA_WIDTH, 32, operand width; TAG_WIDTH, 6, tag width.
REQ-003 SHALL have ports, one clock and one reset: clk, and reset (synchronous, active-low).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 flush  input  1  discard all held entries and the pending issue.
REQ-007 dispatch_valid  input  1  dispatch request.
REQ-008 dispatch_ready  output  1  entry free; combinational, equals (count < DEPTH).
REQ-009 dispatch_tag  input  TAG_WIDTH  destination tag; never 0.
REQ-010 dispatch_opN_valid / dispatch_opN_data / dispatch_opN_tag  input  1/DATA_WIDTH/TAG_WIDTH  operand N (N=1,2): value present, or the producer tag to wait on.
REQ-011 cdb_valid / cdb_tag / cdb_data  input  1/TAG_WIDTH/DATA_WIDTH  common data bus broadcast.
REQ-012 issue_op1 / issue_op2 / issue_tag  output  DATA_WIDTH/DATA_WIDTH/TAG_WIDTH  registered feed to the pipelined multiplier's Operand_1/Operand_2/Tag_in.
REQ-013 issue_valid  output  1  registered; high when issue_tag is non-zero.

Function
REQ-014 Tag 0 SHALL mean "no operation"; idle cycles present issue_tag=0, issue_op1=0, issue_op2=0.
REQ-015 Entries SHALL form a collapsing queue; index 0 is the oldest entry.
REQ-016 Dispatch is accepted at an edge when dispatch_valid && dispatch_ready && !flush; the entry appends after all surviving entries.
REQ-017 A not-ready operand SHALL capture cdb_data at the edge where cdb_valid && cdb_tag == its stored tag; cdb_tag 0 is ignored.
REQ-018 A dispatching operand with !valid and tag == same-cycle cdb_tag (cdb_valid) SHALL be written already valid with cdb_data.
REQ-019 At each edge the lowest-index entry with both operands valid in stored state SHALL be removed and loaded into the issue registers; otherwise the issue registers load zeros.
REQ-020 Latency: dispatch with both operands valid at edge E SHALL appear on issue outputs after edge E+1; CDB wake-up at edge E issues after E+1.
REQ-021 Issue and dispatch in the same edge SHALL both take effect; the count is unchanged.
REQ-022 When full, dispatch_ready=0; a request is ignored with no bypass, even if an issue occurs that edge.
REQ-023 flush SHALL at the next edge empty all entries, zero the issue registers, and reject any same-cycle dispatch.
REQ-024 Issue is one per cycle, with no backpressure; the multiplier accepts every cycle.

Reset
REQ-025 At an edge with reset=0: all entries invalid, count=0, issue outputs 0, issue_valid=0, stall counter 0.
REQ-026 Reset mid-operation SHALL discard all entries; reset has priority over flush, dispatch, CDB and issue.

Configuration
REQ-027 Macro MULT_RS_STATS_EN defined: adds output stall_count (16 bits), which increments each edge with dispatch_valid && !dispatch_ready, saturates at 0xFFFF, and is cleared by reset only.
REQ-028 MULT_RS_STATS_EN undefined: the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold DATA_WIDTH, TAG_WIDTH, the NULL_TAG (0) constant and the rs_entry_t typedef (busy, dest tag, and per operand: valid, tag, data).
REQ-030 One sub-module, mult_rs_entry, SHALL hold one entry plus its CDB wake-up compare; the issue outputs SHALL use the existing Register module.

Verification
REQ-031 Dispatch tag=5, op1=3 valid, op2=7 valid, into an empty RS -> after the following edge issue_tag=5, op1=3, op2=7, issue_valid=1; the next cycle is idle with tag 0.
REQ-032 Dispatch tag=9 with op1 waiting on tag 12; two cycles later CDB tag=12 data=0x10 -> tag 9 issues one edge after the broadcast with op1=0x10.
REQ-033 Fill 4 entries all waiting on tag 20 -> dispatch_ready=0; a 5th dispatch is ignored; CDB tag=20 -> entries issue in dispatch order, one per cycle.
REQ-034 Dispatch op2 waiting on tag 3 in the same cycle as CDB tag=3 data=0xAA -> the entry is ready immediately and issues with op2=0xAA.
REQ-035 Three entries held, then flush asserted with a concurrent dispatch -> after the edge count=0, dispatch_ready=1, issue_tag=0, and no issue occurs later.
REQ-036 reset=0 with 2 ready entries -> after the edge all outputs are 0; with MULT_RS_STATS_EN, stall_count saturates at 0xFFFF under a sustained full-stall.

Source files
------------

// File: rtl/mult_reservation_station_pkg.sv
// Shared types and constants for the multiplier reservation station.
//
// Contents:
//   DATA_WIDTH   - operand width
//   TAG_WIDTH    - tag width
//   NULL_TAG     - tag value meaning "no operation"
//   rs_operand_t - one source operand: valid flag, producer tag, value
//   rs_entry_t   - one station entry: busy, destination tag, two operands
//   wake_operand - applies a CDB broadcast to a single operand
package mult_reservation_station_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned TAG_WIDTH  = 6;

    localparam logic [TAG_WIDTH-1:0] NULL_TAG = '0;

    typedef struct packed {
        logic                  valid;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rs_operand_t;

    typedef struct packed {
        logic                 busy;
        logic [TAG_WIDTH-1:0] dest_tag;
        rs_operand_t          op1;
        rs_operand_t          op2;
    } rs_entry_t;

    // A waiting operand picks up the broadcast value when the producer tag matches.
    // NULL_TAG on the bus never wakes anything.
    function automatic rs_operand_t wake_operand(
        input rs_operand_t           op,
        input logic                  cdb_valid,
        input logic [TAG_WIDTH-1:0]  cdb_tag,
        input logic [DATA_WIDTH-1:0] cdb_data
    );
        rs_operand_t res;
        res = op;
        if (!op.valid && cdb_valid && (cdb_tag != NULL_TAG) && (cdb_tag == op.tag)) begin
            res.valid = 1'b1;
            res.data  = cdb_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_reservation_station_if.sv
// Bus bundle between the reservation station and its environment.
//
// Signals:
//   flush                                  - discard held entries and pending issue
//   dispatch_valid / dispatch_ready        - dispatch handshake
//   dispatch_tag                           - destination tag (never NULL_TAG)
//   dispatch_op{1,2}_valid/_data/_tag      - operand value or producer tag to wait on
//   cdb_valid / cdb_tag / cdb_data         - common data bus broadcast
//   issue_op1 / issue_op2 / issue_tag      - registered feed to the pipelined multiplier
//   issue_valid                            - registered, high when issue_tag is non-zero
//
// Modports: master drives dispatch/CDB/flush, slave is the reservation station.
interface mult_reservation_station_if #(
    parameter int unsigned DATA_WIDTH = mult_reservation_station_pkg::DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = mult_reservation_station_pkg::TAG_WIDTH
);

    logic                  flush;

    logic                  dispatch_valid;
    logic                  dispatch_ready;
    logic [TAG_WIDTH-1:0]  dispatch_tag;
    logic                  dispatch_op1_valid;
    logic [DATA_WIDTH-1:0] dispatch_op1_data;
    logic [TAG_WIDTH-1:0]  dispatch_op1_tag;
    logic                  dispatch_op2_valid;
    logic [DATA_WIDTH-1:0] dispatch_op2_data;
    logic [TAG_WIDTH-1:0]  dispatch_op2_tag;

    logic                  cdb_valid;
    logic [TAG_WIDTH-1:0]  cdb_tag;
    logic [DATA_WIDTH-1:0] cdb_data;

    logic [DATA_WIDTH-1:0] issue_op1;
    logic [DATA_WIDTH-1:0] issue_op2;
    logic [TAG_WIDTH-1:0]  issue_tag;
    logic                  issue_valid;

    modport master (
        output flush,
        output dispatch_valid, dispatch_tag,
        output dispatch_op1_valid, dispatch_op1_data, dispatch_op1_tag,
        output dispatch_op2_valid, dispatch_op2_data, dispatch_op2_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  dispatch_ready,
        input  issue_op1, issue_op2, issue_tag, issue_valid
    );

    modport slave (
        input  flush,
        input  dispatch_valid, dispatch_tag,
        input  dispatch_op1_valid, dispatch_op1_data, dispatch_op1_tag,
        input  dispatch_op2_valid, dispatch_op2_data, dispatch_op2_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output dispatch_ready,
        output issue_op1, issue_op2, issue_tag, issue_valid
    );

endinterface

// File: rtl/Register.sv
// Plain D register with synchronous active-low reset to zero.
//
// Ports:
//   clk   - clock
//   reset - synchronous active-low reset
//   d     - next value
//   q     - registered value
module Register #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/mult_rs_entry.sv
// One reservation-station slot with its CDB wake-up compare.
//
// Ports:
//   clk, reset        - clock, synchronous active-low reset
//   clear             - flush: empty the slot at the next edge
//   write             - load write_entry instead of holding the current contents
//   write_entry       - entry shifted in from the next slot, a new dispatch, or empty
//   cdb_valid/tag/data - broadcast applied to whatever the slot holds next
//   entry             - stored contents
//   ready             - stored entry is busy with both operands valid
module mult_rs_entry
    import mult_reservation_station_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  write,
    input  rs_entry_t             write_entry,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    output rs_entry_t             entry,
    output logic                  ready
);

    rs_entry_t entry_q;
    rs_entry_t entry_d;
    rs_entry_t base;

    // Wake-up is applied after selecting the source, so an entry that moves down the
    // queue, or arrives by dispatch, still catches a same-edge broadcast.
    always_comb begin
        base    = write ? write_entry : entry_q;
        entry_d = base;
        if (base.busy) begin
            entry_d.op1 = wake_operand(base.op1, cdb_valid, cdb_tag, cdb_data);
            entry_d.op2 = wake_operand(base.op2, cdb_valid, cdb_tag, cdb_data);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign entry = entry_q;
    assign ready = entry_q.busy && entry_q.op1.valid && entry_q.op2.valid;

endmodule

// File: rtl/mult_reservation_station.sv
// Reservation station feeding a pipelined multiplier.
//
// A collapsing queue of DEPTH entries (slot 0 oldest). Each edge the oldest entry
// whose stored operands are both valid is removed and registered onto the issue
// outputs; a new dispatch appends behind all surviving entries. Tag 0 on the issue
// outputs means an idle cycle.
//
// Ports:
//   clk         - clock, all state on the rising edge
//   reset       - synchronous active-low reset, overrides everything
//   stall_count - (only with MULT_RS_STATS_EN) saturating count of edges with
//                 dispatch_valid && !dispatch_ready, cleared by reset only
//   rs          - slave side of mult_reservation_station_if
//
// Build option: define MULT_RS_STATS_EN to add the stall_count port and counter.
module mult_reservation_station #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = mult_reservation_station_pkg::DATA_WIDTH,
    parameter int unsigned TAG_WIDTH  = mult_reservation_station_pkg::TAG_WIDTH
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MULT_RS_STATS_EN
    output logic [15:0] stall_count,
`endif
    mult_reservation_station_if.slave rs
);

    import mult_reservation_station_pkg::*;

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ISSUE_W = 1 + TAG_WIDTH + 2 * DATA_WIDTH;

    rs_entry_t          slot [DEPTH];
    logic [DEPTH-1:0]   busy;
    logic [DEPTH-1:0]   ready;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   keep;
    logic [IDX_W-1:0]   issue_idx;
    logic               issue_found;
    logic               dispatch_ready;
    logic               dispatch_fire;
    rs_entry_t          dispatch_entry;
    logic [ISSUE_W-1:0] issue_d;
    logic [ISSUE_W-1:0] issue_q;

    // Busy slots are always contiguous from slot 0, so the population count is the
    // queue length.
    assign count          = CNT_W'($countones(busy));
    assign dispatch_ready = (count < CNT_W'(DEPTH));
    assign dispatch_fire  = rs.dispatch_valid && dispatch_ready && !rs.flush;

    // Lowest ready slot wins; scanning downwards leaves the lowest index last.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IDX_W'(i);
            end
        end
    end

    // Slot index the new dispatch lands in once the issued entry has been removed.
    assign keep = count - CNT_W'(issue_found);

    always_comb begin
        dispatch_entry          = '0;
        dispatch_entry.busy     = 1'b1;
        dispatch_entry.dest_tag = rs.dispatch_tag;
        dispatch_entry.op1      = '{valid: rs.dispatch_op1_valid,
                                    tag:   rs.dispatch_op1_tag,
                                    data:  rs.dispatch_op1_data};
        dispatch_entry.op2      = '{valid: rs.dispatch_op2_valid,
                                    tag:   rs.dispatch_op2_tag,
                                    data:  rs.dispatch_op2_data};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic      write;
        rs_entry_t write_entry;
        rs_entry_t shifted;

        if (g == DEPTH - 1) begin : g_last
            assign shifted = '0;
        end else begin : g_inner
            assign shifted = slot[g + 1];
        end

        // Slots at or above the issued one collapse down by one; the dispatch
        // target overrides whatever would have shifted in.
        always_comb begin
            write       = 1'b0;
            write_entry = '0;
            if (issue_found && (issue_idx <= IDX_W'(g))) begin
                write       = 1'b1;
                write_entry = shifted;
            end
            if (dispatch_fire && (keep == CNT_W'(g))) begin
                write       = 1'b1;
                write_entry = dispatch_entry;
            end
        end

        mult_rs_entry u_entry (
            .clk         (clk),
            .reset       (reset),
            .clear       (rs.flush),
            .write       (write),
            .write_entry (write_entry),
            .cdb_valid   (rs.cdb_valid),
            .cdb_tag     (rs.cdb_tag),
            .cdb_data    (rs.cdb_data),
            .entry       (slot[g]),
            .ready       (ready[g])
        );

        assign busy[g] = slot[g].busy;
    end

    always_comb begin
        issue_d = '0;
        if (issue_found && !rs.flush) begin
            issue_d = {slot[issue_idx].dest_tag != NULL_TAG,
                       slot[issue_idx].dest_tag,
                       slot[issue_idx].op1.data,
                       slot[issue_idx].op2.data};
        end
    end

    Register #(
        .WIDTH (ISSUE_W)
    ) u_issue_reg (
        .clk   (clk),
        .reset (reset),
        .d     (issue_d),
        .q     (issue_q)
    );

    assign {rs.issue_valid, rs.issue_tag, rs.issue_op1, rs.issue_op2} = issue_q;
    assign rs.dispatch_ready = dispatch_ready;

`ifdef MULT_RS_STATS_EN
    logic [15:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else if (rs.dispatch_valid && !dispatch_ready && (stall_count_q != 16'hFFFF)) begin
            stall_count_q <= stall_count_q + 16'd1;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_mult_reservation_station.sv
// Self-checking bench for mult_reservation_station: a queue-based model tracks the
// expected issue stream and occupancy, compared every cycle, plus literal checks.
module tb_mult_reservation_station;

    import mult_reservation_station_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mult_reservation_station_if rs_if ();

`ifdef MULT_RS_STATS_EN
    logic [15:0] stall_count;
`endif

    mult_reservation_station #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
`ifdef MULT_RS_STATS_EN
        .stall_count (stall_count),
`endif
        .rs          (rs_if)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected,
                     $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [TAG_WIDTH-1:0]  tag;
        logic                  v1;
        logic [TAG_WIDTH-1:0]  t1;
        logic [DATA_WIDTH-1:0] d1;
        logic                  v2;
        logic [TAG_WIDTH-1:0]  t2;
        logic [DATA_WIDTH-1:0] d2;
    } m_ent_t;

    m_ent_t                m_q [$];
    logic [TAG_WIDTH-1:0]  exp_tag;
    logic [DATA_WIDTH-1:0] exp_op1;
    logic [DATA_WIDTH-1:0] exp_op2;
    int unsigned           exp_stall;

    function automatic m_ent_t m_wake(input m_ent_t e, input logic cv,
                                      input logic [TAG_WIDTH-1:0] ct,
                                      input logic [DATA_WIDTH-1:0] cd);
        m_ent_t r;
        r = e;
        if (cv && ct != 0) begin
            if (!r.v1 && r.t1 == ct) begin r.v1 = 1'b1; r.d1 = cd; end
            if (!r.v2 && r.t2 == ct) begin r.v2 = 1'b1; r.d2 = cd; end
        end
        return r;
    endfunction

    always @(posedge clk) begin : model
        int     sz;
        int     hit;
        m_ent_t n;
        sz = m_q.size();
        if (!reset) exp_stall = 0;
        else if (rs_if.dispatch_valid && sz >= DEPTH && exp_stall < 65535) exp_stall++;
        exp_tag = '0;
        exp_op1 = '0;
        exp_op2 = '0;
        if (!reset || rs_if.flush) begin
            m_q.delete();
        end else begin
            hit = -1;
            foreach (m_q[i]) if (hit < 0 && m_q[i].v1 && m_q[i].v2) hit = i;
            if (hit >= 0) begin
                exp_tag = m_q[hit].tag;
                exp_op1 = m_q[hit].d1;
                exp_op2 = m_q[hit].d2;
                m_q.delete(hit);
            end
            foreach (m_q[i]) m_q[i] = m_wake(m_q[i], rs_if.cdb_valid, rs_if.cdb_tag,
                                             rs_if.cdb_data);
            if (rs_if.dispatch_valid && sz < DEPTH) begin
                n.tag = rs_if.dispatch_tag;
                n.v1  = rs_if.dispatch_op1_valid;
                n.t1  = rs_if.dispatch_op1_tag;
                n.d1  = rs_if.dispatch_op1_data;
                n.v2  = rs_if.dispatch_op2_valid;
                n.t2  = rs_if.dispatch_op2_tag;
                n.d2  = rs_if.dispatch_op2_data;
                m_q.push_back(m_wake(n, rs_if.cdb_valid, rs_if.cdb_tag, rs_if.cdb_data));
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        check("issue_tag", 64'(rs_if.issue_tag), 64'(exp_tag));
        check("issue_op1", 64'(rs_if.issue_op1), 64'(exp_op1));
        check("issue_op2", 64'(rs_if.issue_op2), 64'(exp_op2));
        check("issue_valid", 64'(rs_if.issue_valid), 64'(exp_tag != 0));
        check("dispatch_ready", 64'(rs_if.dispatch_ready), 64'(m_q.size() < DEPTH));
`ifdef MULT_RS_STATS_EN
        check("stall_count", 64'(stall_count), 64'(exp_stall));
`endif
    end

    // ---------------- stimulus ----------------
    task automatic clear_inputs();
        rs_if.flush              = 1'b0;
        rs_if.dispatch_valid     = 1'b0;
        rs_if.dispatch_tag       = '0;
        rs_if.dispatch_op1_valid = 1'b0;
        rs_if.dispatch_op1_data  = '0;
        rs_if.dispatch_op1_tag   = '0;
        rs_if.dispatch_op2_valid = 1'b0;
        rs_if.dispatch_op2_data  = '0;
        rs_if.dispatch_op2_tag   = '0;
        rs_if.cdb_valid          = 1'b0;
        rs_if.cdb_tag            = '0;
        rs_if.cdb_data           = '0;
    endtask

    task automatic disp(input logic [TAG_WIDTH-1:0] tag,
                        input logic v1, input logic [DATA_WIDTH-1:0] d1,
                        input logic [TAG_WIDTH-1:0] t1,
                        input logic v2, input logic [DATA_WIDTH-1:0] d2,
                        input logic [TAG_WIDTH-1:0] t2);
        rs_if.dispatch_valid     = 1'b1;
        rs_if.dispatch_tag       = tag;
        rs_if.dispatch_op1_valid = v1;
        rs_if.dispatch_op1_data  = d1;
        rs_if.dispatch_op1_tag   = t1;
        rs_if.dispatch_op2_valid = v2;
        rs_if.dispatch_op2_data  = d2;
        rs_if.dispatch_op2_tag   = t2;
    endtask

    task automatic cdb(input logic [TAG_WIDTH-1:0] t, input logic [DATA_WIDTH-1:0] d);
        rs_if.cdb_valid = 1'b1;
        rs_if.cdb_tag   = t;
        rs_if.cdb_data  = d;
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        repeat (2) next();
        check("rst_tag", 64'(rs_if.issue_tag), 64'd0);
        check("rst_valid", 64'(rs_if.issue_valid), 64'd0);
        check("rst_ready", 64'(rs_if.dispatch_ready), 64'd1);
        reset = 1'b1;

        // Both operands ready: issues after the following edge, then idle.
        disp(5, 1, 3, 0, 1, 7, 0);
        next(); clear_inputs();
        check("r31_early", 64'(rs_if.issue_valid), 64'd0);
        next();
        check("r31_tag", 64'(rs_if.issue_tag), 64'd5);
        check("r31_op1", 64'(rs_if.issue_op1), 64'd3);
        check("r31_op2", 64'(rs_if.issue_op2), 64'd7);
        check("r31_valid", 64'(rs_if.issue_valid), 64'd1);
        next();
        check("r31_idle", 64'(rs_if.issue_tag), 64'd0);

        // op1 waits on tag 12, broadcast two cycles later.
        disp(9, 0, 0, 12, 1, 2, 0);
        next(); clear_inputs();
        next();
        cdb(12, 32'h10);
        next(); clear_inputs();
        check("r32_wait", 64'(rs_if.issue_valid), 64'd0);
        next();
        check("r32_tag", 64'(rs_if.issue_tag), 64'd9);
        check("r32_op1", 64'(rs_if.issue_op1), 64'h10);
        check("r32_op2", 64'(rs_if.issue_op2), 64'd2);

        // Same-cycle dispatch and broadcast.
        disp(11, 1, 5, 0, 0, 0, 3);
        cdb(3, 32'hAA);
        next(); clear_inputs();
        next();
        check("r34_tag", 64'(rs_if.issue_tag), 64'd11);
        check("r34_op1", 64'(rs_if.issue_op1), 64'd5);
        check("r34_op2", 64'(rs_if.issue_op2), 64'hAA);

        // Fill, overflow dispatch held across the wake-up and first issue edges.
        for (int k = 0; k < 4; k++) begin
            disp(6'(21 + k), 0, 0, 20, 1, 32'(100 + k), 0);
            next(); clear_inputs();
        end
        check("r33_full", 64'(rs_if.dispatch_ready), 64'd0);
        disp(25, 1, 1, 0, 1, 1, 0);
        next();
        cdb(20, 32'h55);
        next();
        rs_if.cdb_valid = 1'b0;
        next(); clear_inputs();
        for (int k = 0; k < 4; k++) begin
            check("r33_order", 64'(rs_if.issue_tag), 64'(21 + k));
            check("r33_op1", 64'(rs_if.issue_op1), 64'h55);
            check("r33_op2", 64'(rs_if.issue_op2), 64'(100 + k));
            next();
        end
        check("r33_no_25", 64'(rs_if.issue_tag), 64'd0);

        // Middle entry issues first while another dispatches on the same edge.
        disp(41, 0, 0, 60, 1, 1, 0);
        next(); clear_inputs();
        disp(42, 1, 7, 0, 1, 8, 0);
        next(); clear_inputs();
        disp(43, 0, 0, 60, 1, 9, 0);
        next(); clear_inputs();
        check("mid_tag", 64'(rs_if.issue_tag), 64'd42);
        cdb(0, 32'hDEAD);
        next(); clear_inputs();
        cdb(60, 32'h3C);
        next(); clear_inputs();
        next();
        check("mid_a_tag", 64'(rs_if.issue_tag), 64'd41);
        check("mid_a_op1", 64'(rs_if.issue_op1), 64'h3C);
        next();
        check("mid_c_tag", 64'(rs_if.issue_tag), 64'd43);
        check("mid_c_op2", 64'(rs_if.issue_op2), 64'd9);
        next();

        // Flush with a ready entry pending and a concurrent dispatch.
        disp(31, 0, 0, 30, 1, 1, 0);
        next(); clear_inputs();
        disp(32, 1, 2, 0, 0, 0, 30);
        next(); clear_inputs();
        disp(33, 1, 3, 0, 1, 4, 0);
        next(); clear_inputs();
        rs_if.flush = 1'b1;
        disp(34, 1, 5, 0, 1, 6, 0);
        next(); clear_inputs();
        check("r35_ready", 64'(rs_if.dispatch_ready), 64'd1);
        check("r35_tag", 64'(rs_if.issue_tag), 64'd0);
        cdb(30, 32'h77);
        next(); clear_inputs();
        repeat (3) next();
        check("r35_quiet", 64'(rs_if.issue_tag), 64'd0);

        // Reset with two ready entries held.
        disp(50, 0, 0, 61, 1, 1, 0);
        next(); clear_inputs();
        disp(51, 0, 0, 61, 1, 2, 0);
        next(); clear_inputs();
        cdb(61, 32'h11);
        next(); clear_inputs();
        reset = 1'b0;
        next();
        reset = 1'b1;
        check("r36_tag", 64'(rs_if.issue_tag), 64'd0);
        check("r36_op1", 64'(rs_if.issue_op1), 64'd0);
        check("r36_valid", 64'(rs_if.issue_valid), 64'd0);
        check("r36_ready", 64'(rs_if.dispatch_ready), 64'd1);
        repeat (3) next();
        check("r36_quiet", 64'(rs_if.issue_tag), 64'd0);

`ifdef MULT_RS_STATS_EN
        for (int k = 0; k < 4; k++) begin
            disp(6'(1 + k), 0, 0, 62, 1, 1, 0);
            next(); clear_inputs();
        end
        disp(7, 1, 1, 0, 1, 1, 0);
        repeat (65540) next();
        check("stall_sat", 64'(stall_count), 64'hFFFF);
        clear_inputs();
        reset = 1'b0;
        next();
        reset = 1'b1;
        check("stall_reset", 64'(stall_count), 64'd0);
`endif

        next();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
